// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding, line idle
// level and a helper for index widths.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Keeps one-bit-wide frames from producing a zero-width index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_buf.sv
// History shift register of received words, newest in the LS position, with a
// saturating occupancy count. A clear and a load in the same cycle leave one word.
module serial_word_buf
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int BUF_WORDS = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic                          i_clr,
  input  logic [DATA_W-1:0]             i_data,
  output logic [DATA_W*BUF_WORDS-1:0]   o_buf,
  output logic [$clog2(BUF_WORDS+1)-1:0] o_count
);

  localparam int TOT_W = DATA_W * BUF_WORDS;
  localparam int CNT_W = $clog2(BUF_WORDS + 1);

  logic [TOT_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (i_clr) begin
      buf_d = '0;
      cnt_d = '0;
    end
    // Load works on the possibly-cleared value, giving clear-then-load.
    if (i_load) begin
      buf_d = (buf_d << DATA_W) | TOT_W'(i_data);
      if (cnt_d != CNT_W'(BUF_WORDS)) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_buf   = buf_q;
  assign o_count = cnt_q;

endmodule

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock serial frame receiver: start detect, data assembly,
// optional even parity, stop check, and commit into a word history buffer.
//
// state  | meaning
// IDLE   | line idle, waiting for a low start bit
// DATA   | sampling data bits, one per clock
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, deciding commit / error
// BREAK  | line held low after a framing error, wait for high
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int BUF_WORDS = 6,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_rx_bit,
  input  logic                           i_buf_clr,
  output logic [DATA_W-1:0]              o_rx_word,
  output logic                           o_rx_valid,
  output logic                           o_frame_err,
  output logic                           o_parity_err,
  output logic [DATA_W*BUF_WORDS-1:0]    o_key_buf,
  output logic [$clog2(BUF_WORDS+1)-1:0] o_buf_count
);

  localparam int IDX_W = idx_width(DATA_W);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              par_ok_q, par_ok_d;
  logic              commit;
  logic              rx_valid_q, frame_err_q, frame_err_d, parity_err_q, parity_err_d;

  // data_q holds bits in arrival order; word applies the configured bit order.
  always_comb begin
    word = data_q;
    if (LSB_FIRST == 0) begin
      for (int i = 0; i < DATA_W; i++) word[i] = data_q[DATA_W-1-i];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    par_ok_d     = par_ok_q;
    commit       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_bit != LINE_IDLE) begin
          state_d  = ST_DATA;
          idx_d    = '0;
          par_ok_d = 1'b1;
        end
      end
      ST_DATA: begin
        data_d[idx_q] = i_rx_bit;
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        par_ok_d = ~(^data_q ^ i_rx_bit);
        state_d  = ST_STOP;
      end
      ST_STOP: begin
        if (i_rx_bit == LINE_IDLE) begin
          state_d = ST_IDLE;
          if (par_ok_q) commit = 1'b1;
          else          parity_err_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (i_rx_bit == LINE_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rx_word_d = commit ? word : rx_word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      par_ok_q     <= 1'b1;
      rx_word_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      par_ok_q     <= par_ok_d;
      rx_word_q    <= rx_word_d;
      rx_valid_q   <= commit;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  serial_word_buf #(
    .DATA_W   (DATA_W),
    .BUF_WORDS(BUF_WORDS)
  ) u_word_buf (
    .clk    (clk),
    .rst    (rst),
    .i_load (commit),
    .i_clr  (i_buf_clr),
    .i_data (word),
    .o_buf  (o_key_buf),
    .o_count(o_buf_count)
  );

  assign o_rx_word    = rx_word_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and randomized bench for serial_frame_rx: default, parity-enabled
// and MSB-first instances, checked against a queue-based history model.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic buf_clr = 1'b0;
  logic [2:0] rx = 3'b111;

  logic [3:0]  w0, wp, wm;
  logic        v0, vp, vm, fe0, fep, fem, pe0, pep, pem;
  logic [23:0] kb0, kbp, kbm;
  logic [2:0]  c0, cp, cm;

  int n_chk = 0;
  int n_fail = 0;
  int hist[$];

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(4), .BUF_WORDS(6), .LSB_FIRST(1), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .i_rx_bit(rx[0]), .i_buf_clr(buf_clr),
    .o_rx_word(w0), .o_rx_valid(v0), .o_frame_err(fe0), .o_parity_err(pe0),
    .o_key_buf(kb0), .o_buf_count(c0));

  serial_frame_rx #(.DATA_W(4), .BUF_WORDS(6), .LSB_FIRST(1), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .i_rx_bit(rx[1]), .i_buf_clr(buf_clr),
    .o_rx_word(wp), .o_rx_valid(vp), .o_frame_err(fep), .o_parity_err(pep),
    .o_key_buf(kbp), .o_buf_count(cp));

  serial_frame_rx #(.DATA_W(4), .BUF_WORDS(6), .LSB_FIRST(0), .PARITY_EN(0)) dut_m (
    .clk(clk), .rst(rst), .i_rx_bit(rx[2]), .i_buf_clr(buf_clr),
    .o_rx_word(wm), .o_rx_valid(vm), .o_frame_err(fem), .o_parity_err(pem),
    .o_key_buf(kbm), .o_buf_count(cm));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pulses_of(input int k);
    case (k)
      0:       return {v0, fe0, pe0};
      1:       return {vp, fep, pep};
      default: return {vm, fem, pem};
    endcase
  endfunction

  // Frame in send order: bit 0 = start, then data, optional parity, stop.
  function automatic logic [15:0] frame(input logic [3:0] d, input bit stop);
    return {11'd0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] pframe(input logic [3:0] d, input bit par, input bit stop);
    return {10'd0, stop, par, d, 1'b0};
  endfunction

  // Expected history: newest committed word in bits [3:0], at most six words.
  function automatic logic [23:0] exp_buf();
    logic [23:0] r = '0;
    for (int i = 0; i < 6 && i < hist.size(); i++)
      r[i*4 +: 4] = 4'(hist[hist.size()-1-i]);
    return r;
  endfunction

  function automatic logic [2:0] exp_cnt();
    return (hist.size() > 6) ? 3'd6 : 3'(hist.size());
  endfunction

  task automatic send(input int k, input logic [15:0] bits, input int n, input bit clr_last);
    logic [2:0] seen;
    seen = '0;
    for (int i = 0; i < n; i++) begin
      rx[k] = bits[i];
      if (clr_last && i == n - 1) buf_clr = 1'b1;
      tick();
      if (i < n - 1) seen |= pulses_of(k);
    end
    buf_clr = 1'b0;
    rx[k] = 1'b1;
    chk("no_pulse_mid_frame", 32'(seen), 32'd0);
  endtask

  task automatic good0(input logic [3:0] d, input string tag);
    send(0, frame(d, 1'b1), 6, 1'b0);
    hist.push_back(int'(d));
    chk({tag, "_valid"}, 32'(v0), 32'd1);
    chk({tag, "_word"}, 32'(w0), 32'(d));
    chk({tag, "_buf"}, 32'(kb0), 32'(exp_buf()));
    chk({tag, "_cnt"}, 32'(c0), 32'(exp_cnt()));
  endtask

  initial begin
    logic [2:0] seen;
    logic [3:0] d;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_word", 32'(w0), 0);
    chk("rst_pulses", 32'(pulses_of(0)), 0);
    chk("rst_buf", 32'(kb0), 0);
    chk("rst_cnt", 32'(c0), 0);
    tick();

    // Start,1,0,1,1,stop: valid six cycles after the start sample
    good0(4'hD, "t1");
    chk("t1_word_abs", 32'(w0), 32'hD);
    tick();
    chk("t1_pulse_one_cycle", 32'(v0), 0);

    // Clear alone, then seven frames 1..7
    buf_clr = 1'b1;
    tick();
    buf_clr = 1'b0;
    hist.delete();
    chk("clr_cnt", 32'(c0), 0);
    chk("clr_buf", 32'(kb0), 0);
    for (int i = 1; i <= 7; i++) good0(4'(i), "t2");
    chk("t2_buf_abs", 32'(kb0), 32'h234567);
    chk("t2_cnt_sat", 32'(c0), 6);

    // Bad stop bit, then line held low
    send(0, frame(4'hA, 1'b0), 6, 1'b0);
    chk("t3_frame_err", 32'(fe0), 1);
    chk("t3_no_valid", 32'(v0), 0);
    chk("t3_no_perr", 32'(pe0), 0);
    chk("t3_buf_kept", 32'(kb0), 32'h234567);
    rx[0] = 1'b0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= pulses_of(0);
    end
    chk("t3_held_low_quiet", 32'(seen), 0);
    chk("t3_held_low_buf", 32'(kb0), 32'h234567);
    rx[0] = 1'b1;
    tick();
    good0(4'h9, "t3_recover");

    // Random words with random idle gaps, some back-to-back
    for (int r = 0; r < 20; r++) begin
      d = 4'($urandom_range(0, 15));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      good0(d, "rnd");
    end

    // Parity instance: bad parity, good parity, framing error wins
    send(1, pframe(4'b0111, 1'b0, 1'b1), 7, 1'b0);
    chk("t4_parity_err", 32'(pep), 1);
    chk("t4_perr_no_valid", 32'(vp), 0);
    chk("t4_perr_cnt", 32'(cp), 0);
    send(1, pframe(4'b0111, 1'b1, 1'b1), 7, 1'b0);
    chk("t4_valid", 32'(vp), 1);
    chk("t4_word", 32'(wp), 32'h7);
    chk("t4_buf", 32'(kbp), 32'h7);
    chk("t4_cnt", 32'(cp), 1);
    send(1, pframe(4'b0111, 1'b0, 1'b0), 7, 1'b0);
    chk("t4_fe_wins_fe", 32'(fep), 1);
    chk("t4_fe_wins_pe", 32'(pep), 0);
    tick();

    // Reset in the middle of DATA
    rx[0] = 1'b0; tick();
    rx[0] = 1'b1; tick();
    rx[0] = 1'b0; tick();
    rx[0] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hist.delete();
    chk("t5_word", 32'(w0), 0);
    chk("t5_pulses", 32'(pulses_of(0)), 0);
    chk("t5_buf", 32'(kb0), 0);
    chk("t5_cnt", 32'(c0), 0);
    good0(4'h5, "t5_clean");

    // Fill, then clear on the commit cycle
    for (int i = 8; i < 14; i++) good0(4'(i), "t6_fill");
    chk("t6_full", 32'(c0), 6);
    send(0, frame(4'hE, 1'b1), 6, 1'b1);
    hist.delete();
    hist.push_back(14);
    chk("t6_clr_valid", 32'(v0), 1);
    chk("t6_clr_buf", 32'(kb0), 32'(exp_buf()));
    chk("t6_clr_cnt", 32'(c0), 1);

    // MSB-first instance: stream 1,0,1,1 assembles 4'hB
    send(2, frame(4'hD, 1'b1), 6, 1'b0);
    chk("t6_msb_valid", 32'(vm), 1);
    chk("t6_msb_word", 32'(wm), 32'hB);
    chk("t6_msb_buf", 32'(kbm), 32'hB);
    chk("t6_msb_cnt", 32'(cm), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
